pin_entry_controller: RTL

Sequences keypad events from the matrix key decoder into a complete PIN for the door-lock FSM. Edge-detects the decoder's level-valid key strobe. Accumulates BCD digits with backspace and confirm, enforces minimum and maximum length and an inactivity timeout, and presents the PIN over a ready/ack handshake. Letter keys A-D are forwarded as one-cycle command pulses.

---
 rtl/pin_entry_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pin_entry_controller.sv
// Keypad PIN entry: edge-detects decoder strobes, buffers BCD digits with backspace/confirm,
// enforces length limits and an inactivity timeout, and hands the PIN off over ready/ack.
module pin_entry_controller #(
  parameter int MAX_DIGITS     = 8,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [3:0]              key_value,
  input  logic                    key_valid,
  output logic [4*MAX_DIGITS-1:0] pin_data,
  output logic [3:0]              pin_len,
  output logic                    pin_ready,
  input  logic                    pin_ack,
  output logic                    entry_active,
  output logic                    letter_valid,
  output logic [1:0]              letter_code,
  output logic                    err_pulse,
  output logic                    timeout_pulse
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_READY} state_t;

  state_t          state, state_nxt;
  logic            key_valid_d;
  logic            key_event;
  logic [TW-1:0]   timer, timer_nxt;
  logic [DW-1:0]   data_nxt;
  logic [3:0]      len_nxt;
  logic            err_nxt, timeout_nxt, letter_nxt;
  logic [1:0]      code_nxt;

  assign key_event = key_valid & ~key_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // The timer stays at zero outside ENTRY, so entering ENTRY always starts a fresh idle window.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = '0;
    data_nxt    = pin_data;
    len_nxt     = pin_len;
    err_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    letter_nxt  = 1'b0;
    code_nxt    = 2'd0;
    if (!enable) begin
      state_nxt = S_IDLE;
      data_nxt  = '0;
      len_nxt   = '0;
    end else begin
      case (state)
        S_READY: begin
          if (pin_ack) begin
            state_nxt = S_IDLE;
            data_nxt  = '0;
            len_nxt   = '0;
          end
        end
        default: begin
          if (key_event) begin
            if (key_value <= 4'd9) begin
              if (pin_len < 4'(MAX_DIGITS)) begin
                data_nxt  = {pin_data[DW-5:0], key_value};
                len_nxt   = pin_len + 4'd1;
                state_nxt = S_ENTRY;
              end else begin
                err_nxt = 1'b1;
              end
            end else if (key_value == 4'd14) begin
              if (pin_len != 4'd0) begin
                data_nxt = pin_data >> 4;
                len_nxt  = pin_len - 4'd1;
                if (pin_len == 4'd1) state_nxt = S_IDLE;
              end
            end else if (key_value == 4'd15) begin
              if (pin_len >= 4'(MIN_DIGITS)) begin
                state_nxt = S_READY;
              end else begin
                state_nxt = S_IDLE;
                data_nxt  = '0;
                len_nxt   = '0;
                err_nxt   = 1'b1;
              end
            end else begin
              // Codes 10..13 map to 0..3; their low two bits are offset by 2.
              letter_nxt = 1'b1;
              code_nxt   = key_value[1:0] - 2'd2;
            end
          end else if (state == S_ENTRY) begin
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
              state_nxt   = S_IDLE;
              data_nxt    = '0;
              len_nxt     = '0;
              timeout_nxt = 1'b1;
            end else begin
              timer_nxt = timer + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid_d   <= 1'b0;
      timer         <= '0;
      pin_data      <= '0;
      pin_len       <= '0;
      pin_ready     <= 1'b0;
      entry_active  <= 1'b0;
      letter_valid  <= 1'b0;
      letter_code   <= 2'd0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      key_valid_d   <= key_valid;
      timer         <= timer_nxt;
      pin_data      <= data_nxt;
      pin_len       <= len_nxt;
      pin_ready     <= (state_nxt == S_READY);
      entry_active  <= (state_nxt == S_ENTRY);
      letter_valid  <= letter_nxt;
      letter_code   <= code_nxt;
      err_pulse     <= err_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

endmodule
